// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU definitions for the EX stage.
//   div_state_t   state encoding of the iterative divider FSM
//   *_CONTROL     alucontrol codes decoded in EX, including DIV/DIVU
package alu_pkg;

   typedef enum logic [1:0] {
      DIV_IDLE,
      DIV_BUSY,
      DIV_DONE
   } div_state_t;

   localparam logic [3:0] AND_CONTROL   = 4'b0000;
   localparam logic [3:0] OR_CONTROL    = 4'b0001;
   localparam logic [3:0] ADD_CONTROL   = 4'b0010;
   localparam logic [3:0] SUB_CONTROL   = 4'b0110;
   localparam logic [3:0] SLT_CONTROL   = 4'b0111;
   localparam logic [3:0] MULT_CONTROL  = 4'b1000;
   localparam logic [3:0] MULTU_CONTROL = 4'b1001;
   localparam logic [3:0] DIV_CONTROL   = 4'b1010;
   localparam logic [3:0] DIVU_CONTROL  = 4'b1011;

endpackage

// File: rtl/div_step.sv
// div_step: one combinational radix-2 restoring division iteration.
//   rq_in   {R,Q} partial remainder / quotient before the step
//   dvs     divisor magnitude
//   rq_out  {R,Q} after shifting left one bit and trying a subtract
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [2*WIDTH-1:0] rq_in,
   input  logic [WIDTH-1:0]   dvs,
   output logic [2*WIDTH-1:0] rq_out
);

   logic [WIDTH:0] r_shift;
   logic [WIDTH:0] trial;

   // The shifted remainder needs WIDTH+1 bits: R < dvs, so 2R+1 can exceed
   // WIDTH bits but the subtraction result always fits back into WIDTH bits.
   always_comb begin
      r_shift = rq_in[2*WIDTH-1:WIDTH-1];
      trial   = r_shift - {1'b0, dvs};
      if (!trial[WIDTH]) begin
         rq_out = {trial[WIDTH-1:0], rq_in[WIDTH-2:0], 1'b1};
      end else begin
         rq_out = {r_shift[WIDTH-1:0], rq_in[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for MIPS DIV/DIVU in EX.
//   clk_i, rst_i            clock, asynchronous active-high reset
//   start_i, signed_i       EX holds DIV (signed_i=1) or DIVU (signed_i=0)
//   annul_i                 flush/exception: abort whatever is in flight
//   dividend_i, divisor_i   rs / rt, sampled on the accept cycle only
//   lo_o, hi_o              registered quotient / remainder
//   ready_o                 result valid this cycle
//   stall_o                 combinational hold request for IF/ID/EX
module div_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             signed_i,
   input  logic             annul_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] lo_o,
   output logic [WIDTH-1:0] hi_o,
   output logic             ready_o,
   output logic             stall_o
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   div_state_t         state, state_n;
   logic [CNT_W-1:0]   count;
   logic [2*WIDTH-1:0] rq;
   logic [2*WIDTH-1:0] rq_next;
   logic [WIDTH-1:0]   dvs;
   logic               neg_q;
   logic               neg_r;
   logic               accept;
   logic               step_en;
   logic               finish;

   // Two's-complement magnitude; the most negative value maps onto itself,
   // which is the correct unsigned magnitude modulo 2^WIDTH.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                  input logic             is_signed);
      return (is_signed && x[WIDTH-1]) ? -x : x;
   endfunction

   function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] x,
                                                   input logic             neg);
      return neg ? -x : x;
   endfunction

   div_step #(.WIDTH(WIDTH)) u_step (
      .rq_in  (rq),
      .dvs    (dvs),
      .rq_out (rq_next)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= DIV_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      stall_o = 1'b0;
      ready_o = 1'b0;
      accept  = 1'b0;
      step_en = 1'b0;
      finish  = 1'b0;
      case (state)
         DIV_IDLE: begin
            if (start_i && !annul_i) begin
               state_n = DIV_BUSY;
               stall_o = 1'b1;
               accept  = 1'b1;
            end
         end
         DIV_BUSY: begin
            stall_o = 1'b1;
            if (annul_i) begin
               state_n = DIV_IDLE;
            end else begin
               step_en = 1'b1;
               if (count == LAST_CNT) begin
                  state_n = DIV_DONE;
                  finish  = 1'b1;
               end
            end
         end
         DIV_DONE: begin
            // start_i is still the instruction just completed, so never re-accept here.
            ready_o = 1'b1;
            state_n = DIV_IDLE;
         end
         default: state_n = DIV_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count <= '0;
         rq    <= '0;
         dvs   <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         lo_o  <= '0;
         hi_o  <= '0;
      end else begin
         if (accept) begin
            count <= '0;
            rq    <= {{WIDTH{1'b0}}, magnitude(dividend_i, signed_i)};
            dvs   <= magnitude(divisor_i, signed_i);
            neg_q <= signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
            neg_r <= signed_i & dividend_i[WIDTH-1];
         end
         if (step_en) begin
            rq    <= rq_next;
            count <= count + CNT_W'(1);
         end
         // Results land only on the final step, so an annulled op never touches HI/LO.
         if (finish) begin
            lo_o <= apply_sign(rq_next[WIDTH-1:0], neg_q);
            hi_o <= apply_sign(rq_next[2*WIDTH-1:WIDTH], neg_r);
         end
      end
   end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

   logic        clk;
   logic        rst;
   logic        start;
   logic        sgn;
   logic        annul;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic [31:0] lo;
   logic [31:0] hi;
   logic        ready;
   logic        stall;

   int n_tests;
   int n_fail;

   typedef struct {
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] lo;
      logic [31:0] hi;
      string       name;
   } vec_t;

   vec_t vecs [10];

   div_unit #(.WIDTH(32)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .start_i    (start),
      .signed_i   (sgn),
      .annul_i    (annul),
      .dividend_i (dividend),
      .divisor_i  (divisor),
      .lo_o       (lo),
      .hi_o       (hi),
      .ready_o    (ready),
      .stall_o    (stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drives one operation starting in the current cycle (called #1 after an edge)
   // and returns the relative cycle in which ready was seen, plus the count of
   // cycles where stall disagreed with the expected handshake. Returns #1 after
   // the edge that ends the DONE cycle, with start still asserted.
   task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        output int rcyc, output int sbad,
                        output logic [31:0] rlo, output logic [31:0] rhi);
      sgn      = s;
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      rcyc     = -1;
      sbad     = 0;
      rlo      = '0;
      rhi      = '0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (ready) begin
            rcyc = k;
            rlo  = lo;
            rhi  = hi;
            if (stall) sbad++;
         end else if (!stall) begin
            sbad++;
         end
         @(posedge clk);
         #1;
         if (rcyc >= 0) break;
      end
   endtask

   task automatic check_op(input string name, input int rcyc, input int exp_cyc, input int sbad,
                           input logic [31:0] rlo, input logic [31:0] rhi,
                           input logic [31:0] elo, input logic [31:0] ehi);
      chk({name, " ready_cycle"}, 32'(rcyc), 32'(exp_cyc));
      chk({name, " stall_bad_cycles"}, 32'(sbad), 32'd0);
      chk({name, " lo"}, rlo, elo);
      chk({name, " hi"}, rhi, ehi);
      chk({name, " no_x"}, {31'd0, $isunknown({rlo, rhi})}, 32'd0);
   endtask

   initial begin
      int          rcyc;
      int          sbad;
      logic [31:0] rlo;
      logic [31:0] rhi;
      logic        saw_ready;

      n_tests  = 0;
      n_fail   = 0;
      rst      = 1'b1;
      start    = 1'b0;
      sgn      = 1'b0;
      annul    = 1'b0;
      dividend = '0;
      divisor  = '0;

      vecs[0] = '{1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         "divu_100_7"};
      vecs[1] = '{1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF,  "div_m7_2"};
      vecs[2] = '{1'b1, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'd1,         "div_7_m2"};
      vecs[3] = '{1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         "div_overflow"};
      vecs[4] = '{1'b0, 32'd5,         32'd0,         32'hFFFFFFFF,  32'd5,         "divu_by_zero"};
      vecs[5] = '{1'b1, 32'hFFFFFF9C,  32'd7,         32'hFFFFFFF2,  32'hFFFFFFFE,  "div_m100_7"};
      vecs[6] = '{1'b0, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  32'd0,         "divu_max_1"};
      vecs[7] = '{1'b0, 32'h80000000,  32'hFFFFFFFF,  32'd0,         32'h80000000,  "divu_big_divisor"};
      vecs[8] = '{1'b1, 32'hFFFFFFFB,  32'd0,         32'd1,         32'hFFFFFFFB,  "div_m5_by_zero"};
      vecs[9] = '{1'b0, 32'd0,         32'd5,         32'd0,         32'd0,         "divu_0_5"};

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset lo", lo, 32'd0);
      chk("reset hi", hi, 32'd0);
      chk("reset ready", {31'd0, ready}, 32'd0);
      chk("reset stall", {31'd0, stall}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Table-driven single operations
      for (int i = 0; i < 10; i++) begin
         do_op(vecs[i].sgn, vecs[i].a, vecs[i].b, rcyc, sbad, rlo, rhi);
         start = 1'b0;
         check_op(vecs[i].name, rcyc, 33, sbad, rlo, rhi, vecs[i].lo, vecs[i].hi);
      end

      // Back-to-back: start held through DONE; second accepted in cycle 34, ready in 67
      do_op(1'b0, 32'd9, 32'd4, rcyc, sbad, rlo, rhi);
      check_op("b2b_first", rcyc, 33, sbad, rlo, rhi, 32'd2, 32'd1);
      do_op(1'b0, 32'd10, 32'd3, rcyc, sbad, rlo, rhi);
      start = 1'b0;
      check_op("b2b_second", rcyc + 34, 67, sbad, rlo, rhi, 32'd3, 32'd1);

      // Annul in cycle 10 of DIVU 100/7; HI/LO keep 3/1 from the previous op
      sgn       = 1'b0;
      dividend  = 32'd100;
      divisor   = 32'd7;
      start     = 1'b1;
      saw_ready = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (ready) saw_ready = 1'b1;
         @(posedge clk);
         #1;
      end
      annul = 1'b1;
      @(negedge clk);
      chk("annul stall_cycle10", {31'd0, stall}, 32'd1);
      if (ready) saw_ready = 1'b1;
      @(posedge clk);
      #1;
      annul = 1'b0;
      start = 1'b0;
      @(negedge clk);
      chk("annul stall_cycle11", {31'd0, stall}, 32'd0);
      if (ready) saw_ready = 1'b1;
      chk("annul ready_never", {31'd0, saw_ready}, 32'd0);
      chk("annul lo_kept", lo, 32'd3);
      chk("annul hi_kept", hi, 32'd1);
      @(posedge clk);
      #1;
      do_op(1'b0, 32'd9, 32'd3, rcyc, sbad, rlo, rhi);
      start = 1'b0;
      check_op("after_annul", rcyc + 12, 45, sbad, rlo, rhi, 32'd3, 32'd0);

      // annul together with start in IDLE: not accepted, no stall
      sgn      = 1'b0;
      dividend = 32'd20;
      divisor  = 32'd3;
      start    = 1'b1;
      annul    = 1'b1;
      @(negedge clk);
      chk("idle_annul stall", {31'd0, stall}, 32'd0);
      @(posedge clk);
      #1;
      annul = 1'b0;
      do_op(1'b0, 32'd20, 32'd3, rcyc, sbad, rlo, rhi);
      start = 1'b0;
      check_op("idle_annul_then_start", rcyc, 33, sbad, rlo, rhi, 32'd6, 32'd2);

      // Asynchronous reset in the middle of BUSY, between clock edges
      sgn      = 1'b0;
      dividend = 32'd100;
      divisor  = 32'd7;
      start    = 1'b1;
      repeat (15) begin
         @(posedge clk);
         #1;
      end
      #2;
      rst   = 1'b1;
      start = 1'b0;
      #1;
      chk("async_rst lo", lo, 32'd0);
      chk("async_rst hi", hi, 32'd0);
      chk("async_rst ready", {31'd0, ready}, 32'd0);
      chk("async_rst stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      do_op(1'b0, 32'd10, 32'd3, rcyc, sbad, rlo, rhi);
      start = 1'b0;
      check_op("after_rst", rcyc, 33, sbad, rlo, rhi, 32'd3, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
